ahb_slave_if: RTL and testbench
===============================

// Module: ahb_slave_if
// PURPOSE
//  AHB-Lite slave front end of the AHB-APB bridge; the responder to the bridge's AHB master.
//  Samples the address phase, decodes haddr to one of NUM_SLV peripheral selects, captures write data,
//  issues one request to the APB side over a valid/ready handshake, and stalls the AHB bus with hreadyout=0
//  until the response returns. Bad address/size gets a two-cycle AHB ERROR response and no request.
// PARAMETERS
//  NUM_SLV    3             number of decoded peripheral regions
//  BASE_ADDR  32'h8000_0000 start of region 0
//  SLV_SPAN   32'h0400_0000 size of each region; region k = BASE_ADDR + k*SLV_SPAN
// PORTS
//  hclk       in   1        bus clock, all logic on posedge
//  hreset     in   1        asynchronous, active-high reset
//  hwrite     in   1        1=write, 0=read (address phase)
//  hready_in  in   1        combined bus HREADY; address phase is sampled only when 1
//  htrans     in   2        0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//  hsize      in   3        0 byte, 1 halfword, 2 word; others illegal
//  haddr      in   32       transfer address
//  hwdata     in   32       write data (data phase)
//  hreadyout  out  1        0 = wait state inserted
//  hresp      out  1        0 OKAY, 1 ERROR
//  hrdata     out  32       read data
//  req_valid  out  1        APB-side request valid
//  req_ready  in   1        APB side accepts request
//  req_write  out  1        registered hwrite
//  req_addr   out  32       registered haddr
//  req_wdata  out  32       captured hwdata
//  req_strb   out  4        byte lanes from hsize/haddr[1:0]
//  req_sel    out  NUM_SLV  one-hot region select
//  rsp_valid  in   1        APB transfer complete (1-cycle pulse)
//  rsp_rdata  in   32       read data, valid with rsp_valid
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, hreadyout=1, hresp=0, hrdata=0, req_valid=0, req_* all 0.
//   Any in-flight transfer is dropped. No request or response is replayed after reset.
//  Accept: at posedge with hreadyout=1 && hready_in=1 && htrans[1]=1. Register hwrite, haddr, hsize, sel and strb.
//   IDLE/BUSY or hready_in=0: nothing registered, OKAY, zero wait.
//  Legal = haddr inside some region && hsize<=2 && aligned (hsize=1: haddr[0]=0; hsize=2: haddr[1:0]=0).
//  strb: byte = 4'b0001<<haddr[1:0]; half = 4'b0011<<{haddr[1],1'b0}; word = 4'b1111.
//  sel: index = (haddr-BASE_ADDR)/SLV_SPAN; one-hot; region bounds are half-open [base, base+SPAN).
//  FSM (hreadyout=1 only in IDLE, DONE and ERR2; accept is checked in those states):
//   IDLE : accept legal -> DATA; accept illegal -> ERR1; else stay.
//   DATA : hreadyout=0; capture hwdata into req_wdata (writes only) -> REQ.
//   REQ  : req_valid=1. All req_* are held stable until req_ready=1, then -> WAIT (req_valid low next cycle).
//   WAIT : hreadyout=0; on rsp_valid: if read, hrdata<=rsp_rdata -> DONE.
//   DONE : hreadyout=1, hresp=0 for 1 cycle. Accept legal -> DATA; illegal -> ERR1; else IDLE.
//   ERR1 : hreadyout=0, hresp=1 -> ERR2.
//   ERR2 : hreadyout=1, hresp=1. Next state as in DONE.
//  Latency, req_ready=1 and rsp_valid the cycle after the handshake: address at T0,
//   hreadyout low T1..T3, high at T4 (3 wait states).
//  hrdata holds its last read value; it is not updated on writes or errors.
//  rsp_valid outside WAIT and req_ready outside REQ: ignored.
//  A back-to-back transfer accepted in DONE/ERR2 is not delayed further (next DATA immediately).
// TESTING
//  1 Write haddr=0x8000_0004 hsize=2 hwdata=0x24, req_ready=1, rsp at T3 -> one req_valid cycle with
//    addr=0x8000_0004, wdata=0x24, strb=1111, sel=001, write=1; hreadyout 0 at T1..T3, 1 at T4; hresp=0.
//  2 Read 0x8400_0000 with rsp_rdata=0xDEAD_BEEF -> sel=010, write=0; hrdata=0xDEAD_BEEF when hreadyout rises.
//    Back-to-back read issued in DONE -> DATA next cycle.
//  3 NONSEQ to 0x9000_0000; separately hsize=1 @0x8000_0003 -> hresp=1 for 2 cycles, hreadyout 0 then 1;
//    req_valid stays 0.
//  4 hsize=0 @0x8800_0002 -> strb=0100, sel=100. hsize=1 @0x8000_0002 -> strb=1100.
//  5 req_ready held low 5 cycles -> req_* stable, req_valid=1, hreadyout=0 throughout; completes after.
//  6 htrans=0/1, or hready_in=0 with htrans=2 -> no request, hreadyout=1.
//    hreset pulsed in WAIT -> outputs at reset values at once; a later rsp_valid is ignored; next write completes.

Source files
------------

// File: rtl/ahb_slave_if_if.sv
//------------------------------------------------------------------------------
// Module      : ahb_slave_if_if
// Description : AHB-Lite slave bus plus APB-side request/response handshake
//               bundle for the AHB-APB bridge front end.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ahb_slave_if_if #(
   parameter int NUM_SLV = 3
) ();
   // AHB-Lite address/data phase
   logic               hwrite;
   logic               hready_in;
   logic [1:0]         htrans;
   logic [2:0]         hsize;
   logic [31:0]        haddr;
   logic [31:0]        hwdata;
   logic               hreadyout;
   logic               hresp;
   logic [31:0]        hrdata;
   // APB-side request
   logic               req_valid;
   logic               req_ready;
   logic               req_write;
   logic [31:0]        req_addr;
   logic [31:0]        req_wdata;
   logic [3:0]         req_strb;
   logic [NUM_SLV-1:0] req_sel;
   // APB-side response
   logic               rsp_valid;
   logic [31:0]        rsp_rdata;

   // AHB master / APB responder side (drives the bridge)
   modport master (
      output hwrite, hready_in, htrans, hsize, haddr, hwdata,
      output req_ready, rsp_valid, rsp_rdata,
      input  hreadyout, hresp, hrdata,
      input  req_valid, req_write, req_addr, req_wdata, req_strb, req_sel
   );

   // Bridge front end
   modport slave (
      input  hwrite, hready_in, htrans, hsize, haddr, hwdata,
      input  req_ready, rsp_valid, rsp_rdata,
      output hreadyout, hresp, hrdata,
      output req_valid, req_write, req_addr, req_wdata, req_strb, req_sel
   );
endinterface

`default_nettype wire

// File: rtl/ahb_slave_if.sv
//------------------------------------------------------------------------------
// Module      : ahb_slave_if
// Description : AHB-Lite slave front end of the AHB-APB bridge. Decodes the
//               address phase, issues one request to the APB side and stalls
//               the bus until the response returns; illegal transfers get a
//               two-cycle ERROR response and no request.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ahb_slave_if #(
   parameter int          NUM_SLV   = 3,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter logic [31:0] SLV_SPAN  = 32'h0400_0000
) (
   input  logic          hclk,
   input  logic          hreset,
   ahb_slave_if_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_DATA = 3'd1,
      S_REQ  = 3'd2,
      S_WAIT = 3'd3,
      S_DONE = 3'd4,
      S_ERR1 = 3'd5,
      S_ERR2 = 3'd6
   } state_t;

   state_t             state;
   logic [NUM_SLV-1:0] dec_sel;
   logic               in_map;
   logic               aligned;
   logic               legal;
   logic [3:0]         dec_strb;
   logic               accept;

   // Half-open region compare per peripheral; 33-bit math keeps the top
   // region's upper bound from wrapping.
   for (genvar k = 0; k < NUM_SLV; k++) begin : g_region
      localparam logic [32:0] LO = {1'b0, BASE_ADDR} + 33'(k) * {1'b0, SLV_SPAN};
      localparam logic [32:0] HI = LO + {1'b0, SLV_SPAN};
      assign dec_sel[k] = ({1'b0, bus.haddr} >= LO) && ({1'b0, bus.haddr} < HI);
   end

   assign in_map = |dec_sel;
   assign legal  = in_map && aligned;
   // hreadyout is only high in IDLE/DONE/ERR2, so it doubles as the state gate
   assign accept = bus.hreadyout && bus.hready_in && (bus.htrans >= 2'd2);

   // Size legality, alignment and byte-lane decode of the address phase
   always_comb begin
      aligned  = 1'b0;
      dec_strb = 4'b1111;
      case (bus.hsize)
         3'd0: begin
            aligned  = 1'b1;
            dec_strb = 4'b0001 << bus.haddr[1:0];
         end
         3'd1: begin
            aligned  = ~bus.haddr[0];
            dec_strb = 4'b0011 << {bus.haddr[1], 1'b0};
         end
         3'd2: begin
            aligned  = (bus.haddr[1:0] == 2'b00);
            dec_strb = 4'b1111;
         end
         default: begin
            aligned  = 1'b0;
            dec_strb = 4'b1111;
         end
      endcase
   end

   // Transfer FSM with registered bus and request outputs
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state         <= S_IDLE;
         bus.hreadyout <= 1'b1;
         bus.hresp     <= 1'b0;
         bus.hrdata    <= '0;
         bus.req_valid <= 1'b0;
         bus.req_write <= 1'b0;
         bus.req_addr  <= '0;
         bus.req_wdata <= '0;
         bus.req_strb  <= '0;
         bus.req_sel   <= '0;
      end else begin
         case (state)
            // IDLE, DONE and ERR2 all accept a new address phase; a transfer
            // taken here goes straight to DATA with no extra bubble.
            S_IDLE, S_DONE, S_ERR2: begin
               if (accept) begin
                  bus.req_write <= bus.hwrite;
                  bus.req_addr  <= bus.haddr;
                  bus.req_sel   <= dec_sel;
                  bus.req_strb  <= dec_strb;
                  bus.hreadyout <= 1'b0;
                  if (legal) begin
                     state     <= S_DATA;
                     bus.hresp <= 1'b0;
                  end else begin
                     state     <= S_ERR1;
                     bus.hresp <= 1'b1;
                  end
               end else begin
                  state         <= S_IDLE;
                  bus.hreadyout <= 1'b1;
                  bus.hresp     <= 1'b0;
               end
            end
            S_DATA: begin
               if (bus.req_write) begin
                  bus.req_wdata <= bus.hwdata;
               end
               bus.req_valid <= 1'b1;
               state         <= S_REQ;
            end
            S_REQ: begin
               if (bus.req_ready) begin
                  bus.req_valid <= 1'b0;
                  state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.rsp_valid) begin
                  if (!bus.req_write) begin
                     bus.hrdata <= bus.rsp_rdata;
                  end
                  bus.hreadyout <= 1'b1;
                  state         <= S_DONE;
               end
            end
            S_ERR1: begin
               bus.hreadyout <= 1'b1;
               bus.hresp     <= 1'b1;
               state         <= S_ERR2;
            end
            default: begin
               state         <= S_IDLE;
               bus.hreadyout <= 1'b1;
               bus.hresp     <= 1'b0;
               bus.req_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ahb_slave_if.sv
//------------------------------------------------------------------------------
// Module      : tb_ahb_slave_if
// Description : Self-checking bench for ahb_slave_if with directed and
//               randomized transfers against a behavioural address model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ahb_slave_if;

   localparam int          NUM_SLV   = 3;
   localparam logic [31:0] BASE_ADDR = 32'h8000_0000;
   localparam logic [31:0] SLV_SPAN  = 32'h0400_0000;

   logic clk;
   logic rst;
   int   n_asserts;
   int   n_fail;
   logic [31:0] exp_hrdata;

   ahb_slave_if_if #(.NUM_SLV(NUM_SLV)) bus ();

   ahb_slave_if #(
      .NUM_SLV  (NUM_SLV),
      .BASE_ADDR(BASE_ADDR),
      .SLV_SPAN (SLV_SPAN)
   ) u_dut (
      .hclk  (clk),
      .hreset(rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net: the run must never hang
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference decode straight from the address map arithmetic
   task automatic model(input logic [31:0] addr, input logic [2:0] size,
                        output bit lg, output logic [NUM_SLV-1:0] sel, output logic [3:0] strb);
      longint a, b, off, idx;
      int     nbytes;
      bit     in_map, al;
      a      = longint'(addr);
      b      = longint'(BASE_ADDR);
      in_map = (a >= b) && (a < b + longint'(NUM_SLV) * longint'(SLV_SPAN));
      idx    = 0;
      sel    = '0;
      if (in_map) begin
         off = a - b;
         idx = off / longint'(SLV_SPAN);
         sel[idx] = 1'b1;
      end
      nbytes = (size <= 3'd2) ? (1 << size) : 0;
      al     = (nbytes != 0) && ((addr % nbytes) == 0);
      lg     = in_map && al;
      strb   = '0;
      for (int i = 0; i < 4; i++) begin
         if (nbytes != 0 && i >= (addr % 4) && i < (addr % 4) + nbytes) strb[i] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full AHB transfer, checking each cycle. Entered and left with
   // hreadyout expected high, so consecutive calls are back-to-back.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wd, input logic [31:0] rd, input int stall);
      bit                 lg;
      logic [NUM_SLV-1:0] es;
      logic [3:0]         est;
      model(addr, size, lg, es, est);
      bus.htrans    = 2'd2;
      bus.hwrite    = wr;
      bus.haddr     = addr;
      bus.hsize     = size;
      bus.hready_in = 1'b1;
      tick();
      bus.htrans = 2'd0;
      bus.haddr  = $urandom;
      bus.hsize  = 3'($urandom_range(0, 7));
      bus.hwrite = ~wr;
      bus.hwdata = wd;
      chk("t1_hreadyout", 32'(bus.hreadyout), 32'd0);
      chk("t1_hresp", 32'(bus.hresp), 32'(!lg));
      chk("t1_req_valid", 32'(bus.req_valid), 32'd0);
      if (!lg) begin
         tick();
         chk("err2_hreadyout", 32'(bus.hreadyout), 32'd1);
         chk("err2_hresp", 32'(bus.hresp), 32'd1);
         chk("err2_req_valid", 32'(bus.req_valid), 32'd0);
         return;
      end
      tick();
      bus.hwdata = $urandom;
      for (int i = 0; i <= stall; i++) begin
         bus.rsp_valid = (i < stall);
         bus.rsp_rdata = $urandom;
         bus.req_ready = (i == stall);
         chk("req_valid", 32'(bus.req_valid), 32'd1);
         chk("req_hreadyout", 32'(bus.hreadyout), 32'd0);
         chk("req_write", 32'(bus.req_write), 32'(wr));
         chk("req_addr", bus.req_addr, addr);
         chk("req_sel", 32'(bus.req_sel), 32'(es));
         chk("req_strb", 32'(bus.req_strb), 32'(est));
         if (wr) chk("req_wdata", bus.req_wdata, wd);
         tick();
      end
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b1;
      bus.rsp_rdata = rd;
      chk("wait_req_valid", 32'(bus.req_valid), 32'd0);
      chk("wait_hreadyout", 32'(bus.hreadyout), 32'd0);
      tick();
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = $urandom;
      if (!wr) exp_hrdata = rd;
      chk("done_hreadyout", 32'(bus.hreadyout), 32'd1);
      chk("done_hresp", 32'(bus.hresp), 32'd0);
      chk("done_hrdata", bus.hrdata, exp_hrdata);
      chk("done_req_valid", 32'(bus.req_valid), 32'd0);
   endtask

   // A cycle that must not start a transfer
   task automatic no_xfer(input logic [1:0] tr, input logic rdy);
      bus.htrans    = tr;
      bus.hready_in = rdy;
      bus.haddr     = BASE_ADDR;
      bus.hsize     = 3'd2;
      tick();
      bus.htrans    = 2'd0;
      bus.hready_in = 1'b1;
      chk("nox_hreadyout", 32'(bus.hreadyout), 32'd1);
      chk("nox_hresp", 32'(bus.hresp), 32'd0);
      chk("nox_req_valid", 32'(bus.req_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic [2:0]  s;
      int          r;
      n_asserts     = 0;
      n_fail        = 0;
      exp_hrdata    = '0;
      rst           = 1'b1;
      bus.hwrite    = 1'b0;
      bus.hready_in = 1'b1;
      bus.htrans    = 2'd0;
      bus.hsize     = 3'd0;
      bus.haddr     = '0;
      bus.hwdata    = '0;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = '0;
      #1;
      chk("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
      chk("rst_hresp", 32'(bus.hresp), 32'd0);
      chk("rst_hrdata", bus.hrdata, 32'd0);
      chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
      chk("rst_req_addr", bus.req_addr, 32'd0);
      chk("rst_req_sel", 32'(bus.req_sel), 32'd0);
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Basic write, then read followed by a back-to-back read issued in DONE
      xfer(1'b1, 32'h8000_0004, 3'd2, 32'h0000_0024, 32'h0, 0);
      xfer(1'b0, 32'h8400_0000, 3'd2, 32'h0, 32'hDEAD_BEEF, 0);
      xfer(1'b0, 32'h8400_0010, 3'd2, 32'h0, 32'h1234_5678, 0);
      // Error cases: out of map and misaligned halfword; hrdata must survive
      xfer(1'b0, 32'h9000_0000, 3'd2, 32'h0, 32'h0, 0);
      xfer(1'b1, 32'h8000_0003, 3'd1, 32'h55, 32'h0, 0);
      // Lane decode
      xfer(1'b1, 32'h8800_0002, 3'd0, 32'hA5A5_A5A5, 32'h0, 0);
      xfer(1'b1, 32'h8000_0002, 3'd1, 32'h0BAD_F00D, 32'h0, 0);
      // Request held off for 5 cycles
      xfer(1'b1, 32'h8400_0008, 3'd2, 32'hCAFE_0001, 32'h0, 5);
      // Non-transfers
      no_xfer(2'd0, 1'b1);
      no_xfer(2'd1, 1'b1);
      no_xfer(2'd2, 1'b0);

      // Reset while waiting for the response
      bus.htrans = 2'd2; bus.hwrite = 1'b1; bus.haddr = 32'h8000_0000; bus.hsize = 3'd2;
      tick();
      bus.htrans = 2'd0; bus.hwdata = 32'h7777_7777;
      tick();
      bus.req_ready = 1'b1;
      tick();
      bus.req_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      exp_hrdata = '0;
      chk("arst_hreadyout", 32'(bus.hreadyout), 32'd1);
      chk("arst_hresp", 32'(bus.hresp), 32'd0);
      chk("arst_hrdata", bus.hrdata, 32'd0);
      chk("arst_req_valid", 32'(bus.req_valid), 32'd0);
      chk("arst_req_addr", bus.req_addr, 32'd0);
      tick();
      rst = 1'b0;
      bus.rsp_valid = 1'b1;
      bus.rsp_rdata = 32'hFFFF_0000;
      tick();
      bus.rsp_valid = 1'b0;
      chk("late_rsp_hreadyout", 32'(bus.hreadyout), 32'd1);
      chk("late_rsp_hrdata", bus.hrdata, 32'd0);
      chk("late_rsp_req_valid", 32'(bus.req_valid), 32'd0);
      xfer(1'b1, 32'h8000_0010, 3'd2, 32'h0000_4242, 32'h0, 0);

      // Randomized transfers, including region edges and illegal sizes
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 4);
         s = 3'($urandom_range(0, 3));
         case (r)
            0, 1: a = BASE_ADDR + $urandom_range(0, NUM_SLV * SLV_SPAN - 1);
            2:    a = $urandom;
            default: begin
               case ($urandom_range(0, 4))
                  0:       a = BASE_ADDR - 32'd4;
                  1:       a = BASE_ADDR + NUM_SLV * SLV_SPAN;
                  2:       a = BASE_ADDR + NUM_SLV * SLV_SPAN - 32'd4;
                  3:       a = BASE_ADDR + SLV_SPAN - 32'd4;
                  default: a = BASE_ADDR + 2 * SLV_SPAN;
               endcase
            end
         endcase
         if (r != 1 && s <= 3'd2) a = a & ~((32'd1 << s) - 32'd1);
         xfer(1'($urandom_range(0, 1)), a, s, $urandom, $urandom, $urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) no_xfer(2'($urandom_range(0, 1)), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
